imsic_intr_file: RTL

IMSIC_INTR_FILE -- requirements
Module: imsic_intr_file

---
 rtl/imsic_intr_file_if.sv | 26 ++
 rtl/imsic_intr_file.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/imsic_intr_file_if.sv
`default_nettype none
// ============================================================================
// Module   : imsic_intr_file_if
// Brief    : Indirect register access bus of the IMSIC interrupt file.
// Revision : 1.0
// ============================================================================
interface imsic_intr_file_if;
  logic [7:0]  i_reg_addr;
  logic        i_reg_we;
  logic        i_reg_re;
  logic [31:0] i_reg_wdata;
  logic [31:0] o_reg_rdata;
  logic        o_reg_rvalid;
  logic        o_reg_err;

  modport master (
    output i_reg_addr, i_reg_we, i_reg_re, i_reg_wdata,
    input  o_reg_rdata, o_reg_rvalid, o_reg_err
  );

  modport slave (
    input  i_reg_addr, i_reg_we, i_reg_re, i_reg_wdata,
    output o_reg_rdata, o_reg_rvalid, o_reg_err
  );
endinterface
`default_nettype wire

// File: rtl/imsic_intr_file.sv
`default_nettype none
// ============================================================================
// Module   : imsic_intr_file
// Brief    : IMSIC interrupt file: eip/eie arrays, threshold, top-identity
//            selection with claim, and indirect register access.
// Revision : 1.0
// ============================================================================
module imsic_intr_file #(
  parameter int NR_SRC   = 64,
  parameter int NR_SRC_W = $clog2(NR_SRC)
) (
  input  wire logic                i_clk,
  input  wire logic                i_rst,
  imsic_intr_file_if.slave         reg_bus,
  input  wire logic [NR_SRC_W-1:0] i_setipnum,
  input  wire logic                i_setipnum_we,
  input  wire logic                i_claim,
  output logic      [NR_SRC_W-1:0] o_topei,
  output logic                     o_irq
);

  localparam int                c_WORDS    = NR_SRC / 32;
  localparam logic [6:0]        c_WORDS_V  = 7'(NR_SRC / 32);
  localparam logic [NR_SRC_W:0] c_NR_SRC_V = (NR_SRC_W + 1)'(NR_SRC);

  logic [NR_SRC-1:0]   r_eip;
  logic [NR_SRC-1:0]   r_eie;
  logic                r_eidelivery;
  logic [NR_SRC_W-1:0] r_eithreshold;
  logic [NR_SRC_W-1:0] r_topei;
  logic                r_irq;
  logic [31:0]         r_rdata;
  logic                r_rvalid;
  logic                r_err;

  logic [5:0]          w_word;
  logic                w_word_ok;
  logic                w_sel_deliv;
  logic                w_sel_thr;
  logic                w_sel_eip;
  logic                w_sel_eie;
  logic                w_legal;
  logic                w_wr;
  logic                w_setip_ok;
  logic [31:0]         w_rd_data;
  logic [NR_SRC-1:0]   w_eip_nxt;
  logic [NR_SRC-1:0]   w_eie_nxt;
  logic                w_deliv_nxt;
  logic [NR_SRC_W-1:0] w_thr_nxt;
  logic [NR_SRC-1:0]   w_elig;
  logic [NR_SRC_W-1:0] w_topei_nxt;

  // Address decode: eip/eie words beyond the implemented count are illegal.
  assign w_word      = reg_bus.i_reg_addr[5:0];
  assign w_word_ok   = ({1'b0, w_word} < c_WORDS_V);
  assign w_sel_deliv = (reg_bus.i_reg_addr == 8'h70);
  assign w_sel_thr   = (reg_bus.i_reg_addr == 8'h72);
  assign w_sel_eip   = (reg_bus.i_reg_addr[7:6] == 2'b10) && w_word_ok;
  assign w_sel_eie   = (reg_bus.i_reg_addr[7:6] == 2'b11) && w_word_ok;
  assign w_legal     = w_sel_deliv || w_sel_thr || w_sel_eip || w_sel_eie;
  assign w_wr        = reg_bus.i_reg_we && w_legal;
  assign w_setip_ok  = i_setipnum_we && (i_setipnum != '0) &&
                       ({1'b0, i_setipnum} < c_NR_SRC_V);

  always_comb begin
    w_rd_data = '0;
    if (w_sel_deliv) begin
      w_rd_data[0] = r_eidelivery;
    end
    if (w_sel_thr) begin
      w_rd_data[NR_SRC_W-1:0] = r_eithreshold;
    end
    for (int k = 0; k < c_WORDS; k++) begin
      if (w_word == 6'(k)) begin
        if (w_sel_eip) begin
          w_rd_data = r_eip[k*32 +: 32];
        end
        if (w_sel_eie) begin
          w_rd_data = r_eie[k*32 +: 32];
        end
      end
    end
  end

  // Update order on a shared eip bit: register write, claim clear, then set.
  always_comb begin
    w_eip_nxt   = r_eip;
    w_eie_nxt   = r_eie;
    w_deliv_nxt = r_eidelivery;
    w_thr_nxt   = r_eithreshold;
    if (w_wr && w_sel_deliv) begin
      w_deliv_nxt = reg_bus.i_reg_wdata[0];
    end
    if (w_wr && w_sel_thr) begin
      w_thr_nxt = reg_bus.i_reg_wdata[NR_SRC_W-1:0];
    end
    for (int k = 0; k < c_WORDS; k++) begin
      if (w_wr && (w_word == 6'(k))) begin
        if (w_sel_eip) begin
          w_eip_nxt[k*32 +: 32] = reg_bus.i_reg_wdata;
        end
        if (w_sel_eie) begin
          w_eie_nxt[k*32 +: 32] = reg_bus.i_reg_wdata;
        end
      end
    end
    if (i_claim && (r_topei != '0)) begin
      w_eip_nxt[r_topei] = 1'b0;
    end
    if (w_setip_ok) begin
      w_eip_nxt[i_setipnum] = 1'b1;
    end
    w_eip_nxt[0] = 1'b0;
    w_eie_nxt[0] = 1'b0;
  end

  assign w_elig = w_eip_nxt & w_eie_nxt;

  // Descending scan so the lowest eligible identity is the last one kept.
  always_comb begin
    w_topei_nxt = '0;
    for (int i = NR_SRC - 1; i > 0; i--) begin
      if (w_elig[i] && ((w_thr_nxt == '0) || (NR_SRC_W'(i) < w_thr_nxt))) begin
        w_topei_nxt = NR_SRC_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_eip         <= '0;
      r_eie         <= '0;
      r_eidelivery  <= 1'b0;
      r_eithreshold <= '0;
      r_topei       <= '0;
      r_irq         <= 1'b0;
      r_rdata       <= '0;
      r_rvalid      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_eip         <= w_eip_nxt;
      r_eie         <= w_eie_nxt;
      r_eidelivery  <= w_deliv_nxt;
      r_eithreshold <= w_thr_nxt;
      r_topei       <= w_topei_nxt;
      r_irq         <= w_deliv_nxt && (w_topei_nxt != '0);
      r_rdata       <= reg_bus.i_reg_re ? w_rd_data : '0;
      r_rvalid      <= reg_bus.i_reg_re;
      r_err         <= (reg_bus.i_reg_re || reg_bus.i_reg_we) && !w_legal;
    end
  end

  assign o_topei             = r_topei;
  assign o_irq               = r_irq;
  assign reg_bus.o_reg_rdata  = r_rdata;
  assign reg_bus.o_reg_rvalid = r_rvalid;
  assign reg_bus.o_reg_err    = r_err;

endmodule
`default_nettype wire
